// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_stall_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        output if_data_o, if_stall_o, d_rdata_o, d_stall_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        input  if_data_o, if_stall_o, d_rdata_o, d_stall_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and data access; holds the memory bus for LAT cycles per grant.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              owner_d;       // 1 = data port owns the memory, 0 = fetch port
    logic              last_owner_d;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_d;

    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // On a tie, the port that did not win last time gets the memory.
    assign grant_d = bus.d_req_i && (!bus.if_req_i || !last_owner_d);

    assign bus.if_stall_o  = bus.if_req_i && !(state == DONE && !owner_d);
    assign bus.d_stall_o   = bus.d_req_i  && !(state == DONE &&  owner_d);
    assign bus.if_data_o   = if_data_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            owner_d      <= 1'b0;
            last_owner_d <= 1'b0;
            we_q         <= 1'b0;
            cnt          <= '0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        owner_d      <= grant_d;
                        last_owner_d <= grant_d;
                        we_q         <= grant_d && bus.d_we_i;
                        mem_we_q     <= grant_d && bus.d_we_i;
                        mem_en_q     <= 1'b1;
                        mem_addr_q   <= grant_d ? bus.d_addr_i : bus.if_addr_i;
                        if (grant_d)
                            mem_wdata_q <= bus.d_wdata_i;
                        cnt          <= CNT_INIT;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        // Read data is only valid in the last busy cycle.
                        if (!we_q) begin
                            if (owner_d)
                                d_rdata_q <= bus.mem_rdata_i;
                            else
                                if_data_q <= bus.mem_rdata_i;
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-port, fixed-latency unified memory between the CPU's instruction-fetch (IF) path and data-access (MEM-stage) path. It grants one requester at a time and holds the memory interface stable for the full access latency. It captures read data into per-port output registers and drives per-port stall signals that the hazard logic ORs into the pipeline-wide stall. It sits between the IF/MEM stages and the memory model, replacing the separate instruction/data memories when the unified-memory configuration is built.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- LAT, 2, memory access latency in cycles (LAT ≥ 1)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  instruction fetch request (level)
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  registered fetched instruction
- if_stall_o  out  1  IF must hold (combinational)
- d_req_i  in  1  data request (MemRead | MemWrite, level)
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  registered load data
- d_stall_o  out  1  MEM stage must hold (combinational)
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid in last BUSY cycle

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: owner (I/D), last_owner (I/D), cnt (width $clog2(LAT+1)), latched we/addr/wdata.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port opposite last_owner (round-robin).
  - On a grant: latch the requester's addr/we/wdata, set owner, set last_owner := owner, set cnt := LAT - 1, and go to BUSY.
- BUSY:
  - mem_en_o = 1, mem_we_o = latched we (D only; always 0 for I), mem_addr_o/mem_wdata_o = latched values, held constant for all LAT cycles.
  - Decrement cnt each cycle.
  - When cnt == 0: if the access is a read, capture mem_rdata_i into if_data_o or d_rdata_o (per owner); go to DONE.
- DONE: single cycle, memory idle; always go to IDLE next. Requests are never granted from DONE.
- Stall rules:
  - x_stall_o = x_req_i AND NOT (state == DONE AND owner == x).
  - A requester is released only in its own DONE cycle.
- A store never updates d_rdata_o. Each output data register holds its value until its owner's next read completes.
- Requests are level-sensitive. The arbiter does not check that a request is still asserted after the grant. A withdrawn request (e.g. flush) still completes its access; DONE then has no effect on stall.
- In IDLE/DONE, mem_en_o = mem_we_o = 0 and mem_addr_o/mem_wdata_o hold their last values.
- Reset (any state, including mid-BUSY):
  - Next state is IDLE; owner = I; last_owner = I (so the first tie grants D); cnt = 0.
  - if_data_o = 0, d_rdata_o = 0, mem_en_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - An interrupted store may leave memory partially written; this is accepted.

## Timing
- Let request assertion in IDLE be cycle 0.
  - Grant happens at the end of cycle 0.
  - BUSY lasts cycles 1..LAT.
  - DONE is cycle LAT+1; the requester's stall is low there and the pipeline advances at that cycle's edge.
- Stall duration per uncontended access: LAT+1 cycles (cycles 0..LAT). Back-to-back throughput: one access per LAT+2 cycles.
- The losing requester of a tie is granted in the IDLE cycle after the winner's DONE, i.e. cycle LAT+2. Its DONE falls in cycle 2·LAT+3.
- Read data is visible on x_data_o from DONE onward and stays stable until overwritten.

## Test plan
- IF-only read (LAT=2): if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF in cycle 2. Required response:
  - mem_en_o high in cycles 1–2 with mem_addr_o=0x10.
  - if_stall_o high in cycles 0–2 and low in cycle 3.
  - if_data_o=0xDEADBEEF from cycle 3.
- Tie after reset: both requests asserted in cycle 0. Required response:
  - D is granted first (BUSY 1–2, DONE 3, d_stall low in cycle 3).
  - if_stall stays high through cycle 4; I is granted in cycle 4, BUSY 5–6, DONE 7.
- Store: d_req=1, d_we=1, d_addr=0x8, d_wdata=42. Required response:
  - mem_we_o=1 in cycles 1–2 with mem_wdata_o=42.
  - d_rdata_o stays at its prior value.
  - if_data_o unchanged.
- Sustained contention: both requests held high for 16 cycles. Required response: grants alternate D, I, D, I, with each access's DONE at cycles 3, 7, 11, 15.
- Reset mid-BUSY: assert rst_i in cycle 1 of a D read. Required response:
  - In cycle 2, mem_en_o=0, d_rdata_o=0, and the FSM is in IDLE.
  - With d_req still high, a fresh grant occurs in cycle 2 and DONE follows in cycle 5.
- Withdrawn request: drop if_req in cycle 1 of an I access. Required response:
  - mem_en_o still high in cycles 1–2.
  - if_data_o updates in cycle 3.
  - if_stall_o stays low from cycle 1 onward.
